pwm_motor_bank: RTL

Multi-channel H-bridge PWM driver with per-channel duty slew limiting, dead-time-protected direction reversal, active braking and encoder edge counting. It generalises the single-pair motor PWM path to CHANNELS independent bridges that share one PWM period counter. It sits between the drive state machine, which supplies duty, direction and brake targets, and the motor driver pins. Encoder counts are returned to the controller.

---
 rtl/pwm_motor_bank.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_motor_bank.sv
// pwm_motor_bank: shared-period multi-bridge PWM driver with duty slew,
// dead-time reversal, active braking and encoder edge counters.
module pwm_motor_bank #(
  parameter int CHANNELS  = 2,
  parameter int DUTY_W    = 8,
  parameter int PERIOD    = 5000,
  parameter int RAMP_STEP = 4,
  parameter int DEADTIME  = 100,
  parameter int ENC_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       cmd_load,
  input  logic [CHANNELS*DUTY_W-1:0] duty_cmd,
  input  logic [CHANNELS-1:0]        dir_cmd,
  input  logic [CHANNELS-1:0]        brake_cmd,
  input  logic [CHANNELS-1:0]        enc,
  input  logic [CHANNELS-1:0]        enc_clr,
  output logic [CHANNELS-1:0]        pwm1,
  output logic [CHANNELS-1:0]        pwm2,
  output logic [CHANNELS*DUTY_W-1:0] duty_now,
  output logic [2*CHANNELS-1:0]      ch_state,
  output logic [CHANNELS*ENC_W-1:0]  enc_count,
  output logic                       period_start
);
  localparam int CW = $clog2(PERIOD);
  localparam int TW = DUTY_W + $clog2(PERIOD + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic [DW-1:0] DLAST = DW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_REV  = 2'd1,
    S_DEAD = 2'd2,
    S_BRK  = 2'd3
  } st_e;

  logic [CW-1:0] r_cnt;
  logic          r_ps;
  logic          w_bnd;

  assign w_bnd = (r_cnt == LAST);
  assign period_start = r_ps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else begin
      r_cnt <= w_bnd ? '0 : r_cnt + CW'(1);
      r_ps  <= w_bnd;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    st_e               r_st, w_st_n;
    logic [DUTY_W-1:0] r_duty, w_duty_n, r_dtgt;
    logic [DUTY_W-1:0] w_ramp, w_down;
    logic              r_dir, w_dir_n, r_dirt, r_brkt;
    logic [TW-1:0]     r_thr, w_thr_n;
    logic [DW-1:0]     r_dc, w_dc_n;
    logic              r_p1, r_p2, w_act;
    logic [2:0]        r_enc;
    logic [ENC_W-1:0]  r_ecnt;

    assign w_act = (TW'(r_cnt) < r_thr);

    always_comb begin
      w_ramp = r_duty;
      if (r_dtgt > r_duty) begin
        if ({1'b0, r_dtgt - r_duty} > STEP)
          w_ramp = r_duty + STEP[DUTY_W-1:0];
        else
          w_ramp = r_dtgt;
      end else if (r_dtgt < r_duty) begin
        if ({1'b0, r_duty - r_dtgt} > STEP)
          w_ramp = r_duty - STEP[DUTY_W-1:0];
        else
          w_ramp = r_dtgt;
      end
      w_down = ({1'b0, r_duty} > STEP) ?
               r_duty - STEP[DUTY_W-1:0] : '0;
    end

    always_comb begin
      w_st_n   = r_st;
      w_duty_n = r_duty;
      w_dir_n  = r_dir;
      w_dc_n   = r_dc;
      if (!enable) begin
        w_st_n   = S_RUN;
        w_duty_n = '0;
      end else if (r_brkt) begin
        w_st_n   = S_BRK;
        w_duty_n = '0;
      end else begin
        unique case (r_st)
          S_RUN: begin
            if (r_dirt != r_dir) begin
              w_dc_n = '0;
              w_st_n = (r_duty == '0) ? S_DEAD : S_REV;
            end else if (w_bnd) begin
              w_duty_n = w_ramp;
            end
          end
          S_REV: begin
            if (w_bnd) begin
              if (r_dirt == r_dir) begin
                w_st_n = S_RUN;
              end else begin
                w_duty_n = w_down;
                if (w_down == '0) begin
                  w_st_n = S_DEAD;
                  w_dc_n = '0;
                end
              end
            end
          end
          S_DEAD: begin
            if (r_dc == DLAST) begin
              w_st_n  = S_RUN;
              w_dir_n = r_dirt;
            end else begin
              w_dc_n = r_dc + DW'(1);
            end
          end
          S_BRK: begin
            if (w_bnd) begin
              w_st_n  = S_RUN;
              w_dir_n = r_dirt;
            end
          end
          default: ;
        endcase
      end
      // full-width product so no duty bits are lost before the shift
      w_thr_n = (TW'(w_duty_n) * TW'(PERIOD)) >> DUTY_W;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_st   <= S_RUN;
        r_duty <= '0;
        r_dir  <= 1'b0;
        r_dc   <= '0;
        r_thr  <= '0;
        r_dtgt <= '0;
        r_dirt <= 1'b0;
        r_brkt <= 1'b0;
        r_p1   <= 1'b0;
        r_p2   <= 1'b0;
      end else begin
        r_st   <= w_st_n;
        r_duty <= w_duty_n;
        r_dir  <= w_dir_n;
        r_dc   <= w_dc_n;
        if (w_duty_n != r_duty)
          r_thr <= w_thr_n;
        if (cmd_load) begin
          r_dtgt <= duty_cmd[g*DUTY_W +: DUTY_W];
          r_dirt <= dir_cmd[g];
          r_brkt <= brake_cmd[g];
        end
        if (!enable || w_st_n == S_DEAD) begin
          r_p1 <= 1'b0;
          r_p2 <= 1'b0;
        end else if (w_st_n == S_BRK) begin
          r_p1 <= 1'b1;
          r_p2 <= 1'b1;
        end else begin
          r_p1 <= w_dir_n & w_act;
          r_p2 <= ~w_dir_n & w_act;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_enc  <= '0;
        r_ecnt <= '0;
      end else begin
        r_enc <= {r_enc[1:0], enc[g]};
        if (enc_clr[g])
          r_ecnt <= '0;
        else if (r_enc[1] & ~r_enc[2])
          r_ecnt <= r_ecnt + ENC_W'(1);
      end
    end

    assign pwm1[g] = r_p1;
    assign pwm2[g] = r_p2;
    assign duty_now[g*DUTY_W +: DUTY_W] = r_duty;
    assign ch_state[2*g +: 2] = r_st;
    assign enc_count[g*ENC_W +: ENC_W] = r_ecnt;
  end

endmodule
